rcpu_seq_ctrl: RTL and testbench

Multi-cycle sequencing controller for the R-type CPU datapath: instruction ROM (synchronous, 1-cycle read latency), 32x32 register file and 3-bit-opcode ALU. It owns the PC, walks each instruction through fetch/decode/execute/write-back, and gates the register-file write strobe. It latches the ALU flags at write-back and supports single-step (debounced button strobe) and free-run modes. It sits between the board-level step/run controls and the datapath, replacing the free-running PC-on-button-clock scheme.

---
 rtl/rcpu_pkg.sv | 36 +++
 rtl/rcpu_dec.sv | 30 +++
 rtl/rcpu_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_rcpu_seq_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcpu_pkg.sv
// rcpu_pkg: shared state encoding, ALU op codes and R-type func codes
// for the multi-cycle sequencing controller.
package rcpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_NOR = 3'd3;
    localparam logic [2:0] ALU_ADD = 3'd4;
    localparam logic [2:0] ALU_SUB = 3'd5;
    localparam logic [2:0] ALU_SLT = 3'd6;
    localparam logic [2:0] ALU_SLL = 3'd7;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLLV = 6'b000100;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/rcpu_dec.sv
// rcpu_dec: combinational func-field decoder producing the ALU op,
// a legality flag and whether the op reports signed overflow.
module rcpu_dec
    import rcpu_pkg::*;
(
    input  logic [5:0] func_i,
    output logic [2:0] alu_op_o,
    output logic       legal_o,
    output logic       is_addsub_o
);

    always_comb begin
        alu_op_o = ALU_AND;
        legal_o  = 1'b1;
        case (func_i)
            FN_ADD:  alu_op_o = ALU_ADD;
            FN_SUB:  alu_op_o = ALU_SUB;
            FN_AND:  alu_op_o = ALU_AND;
            FN_OR:   alu_op_o = ALU_OR;
            FN_XOR:  alu_op_o = ALU_XOR;
            FN_NOR:  alu_op_o = ALU_NOR;
            FN_SLT:  alu_op_o = ALU_SLT;
            FN_SLLV: alu_op_o = ALU_SLL;
            default: legal_o  = 1'b0;
        endcase
    end

    assign is_addsub_o = (func_i == FN_ADD) || (func_i == FN_SUB);

endmodule

// File: rtl/rcpu_seq_ctrl.sv
// rcpu_seq_ctrl: multi-cycle fetch/wait/decode/execute/write-back sequencer
// owning the PC, IR, register-file write strobe and ALU flag register.
module rcpu_seq_ctrl
    import rcpu_pkg::*;
#(
    parameter int ROM_AW = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              run,
    input  logic [31:0]       inst,
    input  logic              alu_zf,
    input  logic              alu_of,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [31:0]       pc,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [2:0]        alu_op,
    output logic              reg_we,
    output logic              fr_zf,
    output logic              fr_of,
    output logic              retire,
    output logic              busy,
    output logic              halted,
    output logic              trap,
    output logic [CNT_W-1:0]  icount
);

    state_t           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      ir_q;
    logic [2:0]       alu_op_q;
    logic             is_addsub_q;
    logic             rom_en_q;
    logic             reg_we_q;
    logic             retire_q;
    logic             fr_zf_q;
    logic             fr_of_q;
    logic [CNT_W-1:0] icount_q;
    logic [2:0]       dec_op;
    logic             dec_legal;
    logic             dec_addsub;
    logic             inst_ok;

    rcpu_dec u_dec (
        .func_i     (inst[5:0]),
        .alu_op_o   (dec_op),
        .legal_o    (dec_legal),
        .is_addsub_o(dec_addsub)
    );

    assign inst_ok = (inst[31:26] == 6'd0) && dec_legal;

    // Strobes are registered and set on entry to their state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            alu_op_q    <= '0;
            is_addsub_q <= 1'b0;
            rom_en_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            retire_q    <= 1'b0;
            fr_zf_q     <= 1'b0;
            fr_of_q     <= 1'b0;
            icount_q    <= '0;
        end else begin
            rom_en_q <= 1'b0;
            reg_we_q <= 1'b0;
            retire_q <= 1'b0;
            case (state_q)
                S_IDLE: if (step || run) begin
                    state_q  <= S_FETCH;
                    rom_en_q <= 1'b1;
                end
                S_FETCH: state_q <= S_WAIT;
                S_WAIT:  state_q <= S_DECODE;
                S_DECODE: begin
                    ir_q <= inst;
                    if (inst == HALT_WORD) begin
                        state_q <= S_HALT;
                    end else if (!inst_ok) begin
                        state_q <= S_TRAP;
                    end else begin
                        pc_q        <= pc_q + 32'd4;
                        alu_op_q    <= dec_op;
                        is_addsub_q <= dec_addsub;
                        state_q     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_q  <= S_WB;
                    reg_we_q <= ir_q[15:11] != 5'd0;
                    retire_q <= 1'b1;
                end
                S_WB: begin
                    fr_zf_q  <= alu_zf;
                    fr_of_q  <= is_addsub_q && alu_of;
                    icount_q <= icount_q + CNT_W'(1);
                    state_q  <= run ? S_FETCH : S_IDLE;
                    rom_en_q <= run;
                end
                S_HALT:  state_q <= S_HALT;
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rom_en   = rom_en_q;
    assign rom_addr = pc_q[ROM_AW+1:2];
    assign pc       = pc_q;
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign alu_op   = alu_op_q;
    assign reg_we   = reg_we_q;
    assign fr_zf    = fr_zf_q;
    assign fr_of    = fr_of_q;
    assign retire   = retire_q;
    assign icount   = icount_q;
    assign busy     = !(state_q inside {S_IDLE, S_HALT, S_TRAP});
    assign halted   = state_q == S_HALT;
    assign trap     = state_q == S_TRAP;

endmodule

// File: tb/tb_rcpu_seq_ctrl.sv
// tb_rcpu_seq_ctrl: scenario tasks driving rcpu_seq_ctrl against a ROM array
// and an instruction-level reference model of expected retirements.
module tb_rcpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step = 1'b0;
    logic        run = 1'b0;
    logic        alu_zf = 1'b0;
    logic        alu_of = 1'b0;
    logic [31:0] inst = '0;
    logic        rom_en, reg_we, fr_zf, fr_of, retire, busy, halted, trap;
    logic [5:0]  rom_addr;
    logic [31:0] pc;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  alu_op;
    logic [15:0] icount;
    logic [31:0] rom [64];
    logic [5:0]  legal_fn [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h04};
    int          n_checks = 0;
    int          n_fail = 0;

    rcpu_seq_ctrl #(.ROM_AW(6), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .step(step), .run(run), .inst(inst),
        .alu_zf(alu_zf), .alu_of(alu_of), .rom_en(rom_en), .rom_addr(rom_addr),
        .pc(pc), .rs(rs), .rt(rt), .rd(rd), .alu_op(alu_op), .reg_we(reg_we),
        .fr_zf(fr_zf), .fr_of(fr_of), .retire(retire), .busy(busy),
        .halted(halted), .trap(trap), .icount(icount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) inst <= rom[rom_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] exp_op(input logic [5:0] f);
        case (f)
            6'h20: return 3'd4;
            6'h22: return 3'd5;
            6'h24: return 3'd0;
            6'h25: return 3'd1;
            6'h26: return 3'd2;
            6'h27: return 3'd3;
            6'h2a: return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [31:0] rtype(input int r_s, input int r_t, input int r_d, input logic [5:0] f);
        return {6'd0, 5'(r_s), 5'(r_t), 5'(r_d), 5'd0, f};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step = 1'b0;
        run = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_checks++;
        if ({rom_en, reg_we, retire, busy, halted, trap, fr_zf, fr_of} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 00000000", {rom_en, reg_we, retire, busy, halted, trap, fr_zf, fr_of});
        end
        n_checks++;
        if (pc !== 32'd0 || rom_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_pc: got pc=%h addr=%h want 0", pc, rom_addr);
        end
        n_checks++;
        if ({rs, rt, rd, alu_op} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_fields: got rs=%0d rt=%0d rd=%0d op=%0d want 0", rs, rt, rd, alu_op);
        end
        n_checks++;
        if (icount !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_icount: got %0d want 0", icount);
        end
        rst = 1'b0;
        tick;
        n_checks++;
        if (busy !== 1'b0 || rom_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_hold: got busy=%b rom_en=%b want 0 0", busy, rom_en);
        end
    endtask

    task automatic test_step_add;
        int early = 0;
        do_reset;
        rom[0] = 32'h0022_1820;
        step = 1'b1;
        tick;
        step = 1'b0;
        n_checks++;
        if (rom_en !== 1'b1 || rom_addr !== 6'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL step_fetch: got rom_en=%b addr=%0d busy=%b want 1 0 1", rom_en, rom_addr, busy);
        end
        for (int c = 2; c <= 4; c++) begin
            tick;
            if (retire || reg_we || rom_en) early++;
        end
        n_checks++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL step_early_strobe: got %0d strobed cycles want 0", early);
        end
        tick;
        n_checks++;
        if ({retire, reg_we, rd, alu_op, rs, rt} !== {1'b1, 1'b1, 5'd3, 3'd4, 5'd1, 5'd2}) begin
            n_fail++;
            $display("FAIL step_wb: got retire=%b we=%b rd=%0d op=%0d rs=%0d rt=%0d want 1 1 3 4 1 2", retire, reg_we, rd, alu_op, rs, rt);
        end
        alu_zf = 1'b1;
        alu_of = 1'b1;
        tick;
        n_checks++;
        if ({pc, icount, busy, retire, reg_we, fr_zf, fr_of} !== {32'd4, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL step_after: got pc=%0d icount=%0d busy=%b retire=%b we=%b zf=%b of=%b want 4 1 0 0 0 1 1", pc, icount, busy, retire, reg_we, fr_zf, fr_of);
        end
        alu_zf = 1'b0;
        alu_of = 1'b0;
    endtask

    task automatic test_run(input bit fixed, input int n);
        logic [31:0] prog [$];
        logic [31:0] cur;
        logic        ez, eo, pend;
        int          k, last, bad;
        logic [31:0] pc_h;
        logic [15:0] ic_h;
        do_reset;
        prog = {};
        for (int i = 0; i < n; i++) begin
            if (fixed) prog.push_back(rtype($urandom_range(0, 31), $urandom_range(0, 31), i + 1, legal_fn[(i == 0) ? 1 : i + 1]));
            else prog.push_back(rtype($urandom_range(0, 31), $urandom_range(0, 31),
                                      ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31), legal_fn[$urandom_range(0, 7)]));
            rom[i] = prog[i];
        end
        rom[n] = 32'hFFFF_FFFF;
        k = 0;
        last = 0;
        pend = 1'b0;
        ez = 1'b0;
        eo = 1'b0;
        run = 1'b1;
        for (int c = 1; c <= 5 * n + 20; c++) begin
            tick;
            if (pend) begin
                n_checks++;
                if (fr_zf !== ez || fr_of !== eo) begin
                    n_fail++;
                    $display("FAIL run_flags[%0d]: got zf=%b of=%b want %b %b", k - 1, fr_zf, fr_of, ez, eo);
                end
                pend = 1'b0;
            end
            cur = (k < n) ? prog[k] : 32'd0;
            if (retire) begin
                n_checks++;
                if (k >= n) begin
                    n_fail++;
                    $display("FAIL run_extra_retire: got retire %0d want at most %0d", k + 1, n);
                end else if (c - last !== 5 || alu_op !== exp_op(cur[5:0]) || rd !== cur[15:11] ||
                             rs !== cur[25:21] || rt !== cur[20:16] || reg_we !== (cur[15:11] != 5'd0) ||
                             pc !== 32'(4 * (k + 1)) || icount !== 16'(k)) begin
                    n_fail++;
                    $display("FAIL run_retire[%0d]: got gap=%0d op=%0d rd=%0d rs=%0d rt=%0d we=%b pc=%0d ic=%0d want 5 %0d %0d %0d %0d %b %0d %0d",
                             k, c - last, alu_op, rd, rs, rt, reg_we, pc, icount, exp_op(cur[5:0]),
                             cur[15:11], cur[25:21], cur[20:16], cur[15:11] != 5'd0, 4 * (k + 1), k);
                end
                last = c;
                k++;
            end
            alu_zf = 1'($urandom_range(0, 1));
            alu_of = 1'($urandom_range(0, 1));
            if (retire) begin
                ez = alu_zf;
                eo = (cur[5:0] == 6'h20 || cur[5:0] == 6'h22) ? alu_of : 1'b0;
                pend = 1'b1;
            end
            if (halted) break;
        end
        n_checks++;
        if ({halted, busy, trap} !== 3'b100 || k !== n || pc !== 32'(4 * n) || icount !== 16'(n)) begin
            n_fail++;
            $display("FAIL run_halt: got halted=%b busy=%b trap=%b retired=%0d pc=%0d ic=%0d want 1 0 0 %0d %0d %0d",
                     halted, busy, trap, k, pc, icount, n, 4 * n, n);
        end
        pc_h = pc;
        ic_h = icount;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            step = 1'(c % 2);
            run = 1'(c % 3 != 0);
            tick;
            if (!halted || retire || rom_en || busy) bad++;
        end
        step = 1'b0;
        run = 1'b0;
        n_checks++;
        if (bad !== 0 || pc !== pc_h || icount !== ic_h) begin
            n_fail++;
            $display("FAIL halt_absorbing: got bad=%0d pc=%0d ic=%0d want 0 %0d %0d", bad, pc, icount, pc_h, ic_h);
        end
    endtask

    task automatic test_trap(input logic [31:0] bad_word);
        int n_we = 0;
        int n_ret = 0;
        int bad = 0;
        do_reset;
        rom[0] = rtype(1, 2, 4, 6'h20);
        rom[1] = rtype(3, 2, 6, 6'h22);
        rom[2] = bad_word;
        run = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick;
            n_we += int'(reg_we);
            n_ret += int'(retire);
            if (trap) break;
        end
        n_checks++;
        if ({trap, halted, busy} !== 3'b100 || pc !== 32'd8 || icount !== 16'd2 || n_we !== 2 || n_ret !== 2) begin
            n_fail++;
            $display("FAIL trap_entry(%h): got trap=%b halted=%b busy=%b pc=%0d ic=%0d we=%0d ret=%0d want 1 0 0 8 2 2 2",
                     bad_word, trap, halted, busy, pc, icount, n_we, n_ret);
        end
        for (int c = 0; c < 10; c++) begin
            step = 1'(c % 2);
            tick;
            if (!trap || reg_we || retire || rom_en) bad++;
        end
        step = 1'b0;
        run = 1'b0;
        n_checks++;
        if (bad !== 0 || pc !== 32'd8 || icount !== 16'd2) begin
            n_fail++;
            $display("FAIL trap_absorbing(%h): got bad=%0d pc=%0d ic=%0d want 0 8 2", bad_word, bad, pc, icount);
        end
    endtask

    task automatic test_r0_flags;
        bit found;
        do_reset;
        rom[0] = rtype(1, 2, 0, 6'h20);
        rom[1] = rtype(1, 2, 5, 6'h26);
        for (int pass = 0; pass < 2; pass++) begin
            step = 1'b1;
            tick;
            step = 1'b0;
            found = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick;
                if (retire) begin
                    found = 1'b1;
                    break;
                end
            end
            n_checks++;
            if (!found || reg_we !== (pass == 1) || alu_op !== ((pass == 1) ? 3'd2 : 3'd4)) begin
                n_fail++;
                $display("FAIL r0_wb[%0d]: got found=%b we=%b op=%0d want 1 %b %0d", pass, found, reg_we, alu_op, pass == 1, (pass == 1) ? 2 : 4);
            end
            alu_zf = 1'(pass);
            alu_of = 1'b1;
            tick;
            n_checks++;
            if (fr_zf !== 1'(pass) || fr_of !== (pass == 0)) begin
                n_fail++;
                $display("FAIL r0_flags[%0d]: got zf=%b of=%b want %b %b", pass, fr_zf, fr_of, 1'(pass), pass == 0);
            end
        end
        alu_zf = 1'b0;
        alu_of = 1'b0;
    endtask

    task automatic test_extra_steps;
        int n_ret = 0;
        do_reset;
        rom[0] = rtype($urandom_range(0, 31), $urandom_range(0, 31), 7, 6'h25);
        step = 1'b1;
        tick;
        step = 1'b0;
        for (int c = 2; c <= 14; c++) begin
            tick;
            n_ret += int'(retire);
            step = (c == 2 || c == 4);
        end
        step = 1'b0;
        n_checks++;
        if (n_ret !== 1 || busy !== 1'b0 || pc !== 32'd4 || icount !== 16'd1) begin
            n_fail++;
            $display("FAIL extra_steps: got retires=%0d busy=%b pc=%0d ic=%0d want 1 0 4 1", n_ret, busy, pc, icount);
        end
    endtask

    task automatic test_rst_exec;
        bit found;
        do_reset;
        rom[0] = rtype(1, 2, 3, 6'h20);
        step = 1'b1;
        tick;
        step = 1'b0;
        tick;
        tick;
        tick;
        n_checks++;
        if (busy !== 1'b1 || pc !== 32'd4 || alu_op !== 3'd4) begin
            n_fail++;
            $display("FAIL rst_pre_exec: got busy=%b pc=%0d op=%0d want 1 4 4", busy, pc, alu_op);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rom_en, reg_we, retire, busy} !== 4'd0 || pc !== 32'd0 || {rd, alu_op} !== 8'd0 || icount !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_async: got strobes=%b pc=%0d rd=%0d op=%0d ic=%0d want 0000 0 0 0 0", {rom_en, reg_we, retire, busy}, pc, rd, alu_op, icount);
        end
        tick;
        tick;
        n_checks++;
        if (retire !== 1'b0 || reg_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_retire: got retire=%b we=%b want 0 0", retire, reg_we);
        end
        rst = 1'b0;
        step = 1'b1;
        tick;
        step = 1'b0;
        n_checks++;
        if (rom_en !== 1'b1 || rom_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL rst_refetch: got rom_en=%b addr=%0d want 1 0", rom_en, rom_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (retire) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found || rd !== 5'd3 || icount !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_rerun: got found=%b rd=%0d ic=%0d want 1 3 0", found, rd, icount);
        end
    endtask

    initial begin
        test_reset;
        test_step_add;
        test_run(1'b1, 4);
        for (int r = 0; r < 4; r++) test_run(1'b0, $urandom_range(6, 14));
        test_trap({6'h23, 26'($urandom)});
        test_trap(rtype(1, 2, 3, 6'h21));
        test_r0_flags;
        test_extra_steps;
        test_rst_exec;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
